fp_unpacker: RTL and testbench
==============================

// Module: fp_unpacker
// PURPOSE
//  Registered IEEE-754 operand unpacker at the FPU input stage. Splits a packed
//  double, or a single held in fp[63:32], into sign, exponent, significand and
//  class flags. Optionally left-normalises denormal significands. One-cycle latency.
// PARAMETERS
//  none (widths fixed: fp 64, e 11, f 53, h 52, lz 6; constants come from fp_pkg)
// PORTS
//  clk     in   1   clock, rising edge
//  rst     in   1   reset, asynchronous, active-high
//  in_vld  in   1   input operand valid
//  fp      in   64  packed operand (single: fp[63:32], fp[31:0] ignored)
//  db      in   1   1=double, 0=single
//  normal  in   1   1=output f left-normalised by lz
//  out_vld out  1   outputs valid (in_vld delayed 1 cycle)
//  s       out  1   sign
//  e       out  11  raw biased exponent field, zero-extended (single: {3'b0,E8})
//  e_z     out  1   exponent field all zeros
//  e_inf   out  1   exponent field all ones (single: E8==8'hFF)
//  h       out  52  fraction field, left-aligned (single: {F23,29'b0})
//  fz      out  1   fraction field all zeros
//  f       out  53  {~e_z, h}, shifted left by lz when normal=1
//  lz      out  6   leading-zero count of unshifted {~e_z,h}; 53 when all zero
// BEHAVIOUR
//  - All outputs registered; every output resets to 0 asynchronously on rst=1.
//  - A result is captured every cycle regardless of in_vld; out_vld <= in_vld.
//    There is no back-pressure.
//  - Field select: db=1 -> s=fp[63], E=fp[62:52], F=fp[51:0];
//    db=0 -> s=fp[63], E=fp[62:55], F={fp[54:32],29'b0}.
//  - The hidden bit is ~e_z. Denormals and zero keep e=0 (no rebias or exponent adjust).
//  - lz is counted over the 53-bit {hidden,F}, range 0..53. Zero yields lz=53 and f=0.
//  - normal=1: f={hidden,F}<<lz (normalised values unchanged). normal=0: f unshifted.
//  - Single trailing pad bits are always 0, so the same counter/shifter serves both formats.
//  - rst asserted mid-stream clears out_vld and the outputs immediately.
//    The first capture happens on the first clk edge after rst deasserts.
// CONFIGURATION
//  FP_UNPACK_NAN_EN defined: adds outputs nan (e_inf & ~fz) and snan
//    (nan & ~h[51]). Both are registered, reset to 0, and use the same latency.
//  Not defined: the nan/snan ports and their logic are absent; all else unchanged.
// STRUCTURE
//  fp_pkg: widths (FP_W=64, EXP_W=11, SIG_W=53, LZ_W=6), single/double field
//    offsets, SGL_PAD=29, EXP_ONES constants.
//  Sub-module lzc53: combinational 53-bit leading-zero counter, output 6 bits (53 on zero).
//  Normalising shifter, flags and output registers live in fp_unpacker.
// TESTING
//  1 fp=0, db=1, normal=1 -> s=0 e=0 e_z=1 e_inf=0 fz=1 h=0 f=0 lz=53, out_vld 1 cycle later.
//  2 fp=64'h3FF0000000000000, db=0, normal=0 -> s=0 e=11'd127 e_z=0 e_inf=0
//    h={23'h700000,29'b0} fz=0 f={1'b1,h} lz=0.
//  3 fp=64'hBFF0000000000000, db=1, normal=1 -> s=1 e=11'h3FF fz=1 h=0 f=53'h1<<52 lz=0.
//  4 fp=64'h7FF0000000000000, db=0 -> e=11'd255 e_inf=1 fz=0
//    (with FP_UNPACK_NAN_EN: nan=1 snan=0). With db=1 -> e=11'h7FF e_inf=1 fz=1 nan=0.
//  5 fp=64'h0000000000000001, db=1: normal=1 -> e_z=1 lz=52 f=53'h1<<52;
//    normal=0 -> f=53'h1 lz=52.
//  6 Assert rst between two in_vld pulses -> all outputs 0 at once; the next
//    operand appears 1 cycle after release.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared widths, IEEE-754 field offsets and constants for the FPU input stage,
// plus the registered result record produced by fp_unpacker.
// Optional feature macro: FP_UNPACK_NAN_EN adds nan/snan to the result record.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_W   = 64;  // packed operand width
  localparam int EXP_W  = 11;  // exponent output width (double field width)
  localparam int SIG_W  = 53;  // {hidden, fraction}
  localparam int FRAC_W = 52;  // fraction field width, left-aligned
  localparam int LZ_W   = 6;   // holds 0..53

  // Double-precision field positions
  localparam int SIGN_BIT     = 63;
  localparam int DBL_EXP_MSB  = 62;
  localparam int DBL_EXP_LSB  = 52;
  localparam int DBL_FRAC_MSB = 51;
  localparam int DBL_FRAC_LSB = 0;

  // Single-precision field positions (single lives in fp[63:32])
  localparam int SGL_EXP_W    = 8;
  localparam int SGL_EXP_MSB  = 62;
  localparam int SGL_EXP_LSB  = 55;
  localparam int SGL_FRAC_MSB = 54;
  localparam int SGL_FRAC_LSB = 32;
  localparam int SGL_PAD      = 29;  // zero bits appended below F23

  localparam logic [EXP_W-1:0]     DBL_EXP_ONES = 11'h7FF;
  localparam logic [SGL_EXP_W-1:0] SGL_EXP_ONES = 8'hFF;

  typedef struct packed {
    logic              vld;
    logic              s;
    logic [EXP_W-1:0]  e;
    logic              e_z;
    logic              e_inf;
    logic [FRAC_W-1:0] h;
    logic              fz;
    logic [SIG_W-1:0]  f;
    logic [LZ_W-1:0]   lz;
`ifdef FP_UNPACK_NAN_EN
    logic              nan;
    logic              snan;
`endif
  } unpack_t;

endpackage

// File: rtl/fp_unpacker_if.sv
// -----------------------------------------------------------------------------
// fp_unpacker_if
// Operand-in / fields-out bundle of the unpacker.
//   master : drives in_vld, fp, db, normal; receives the unpacked fields
//   slave  : the unpacker itself
// Inputs : in_vld, fp[63:0], db (1=double), normal (1=left-normalise f)
// Outputs: out_vld, s, e[10:0], e_z, e_inf, h[51:0], fz, f[52:0], lz[5:0]
//          (+ nan, snan when FP_UNPACK_NAN_EN is defined)
// -----------------------------------------------------------------------------
interface fp_unpacker_if;
  import fp_pkg::*;

  logic              in_vld;
  logic [FP_W-1:0]   fp;
  logic              db;
  logic              normal;

  logic              out_vld;
  logic              s;
  logic [EXP_W-1:0]  e;
  logic              e_z;
  logic              e_inf;
  logic [FRAC_W-1:0] h;
  logic              fz;
  logic [SIG_W-1:0]  f;
  logic [LZ_W-1:0]   lz;

`ifdef FP_UNPACK_NAN_EN
  logic              nan;
  logic              snan;

  modport master (
    output in_vld, fp, db, normal,
    input  out_vld, s, e, e_z, e_inf, h, fz, f, lz, nan, snan
  );
  modport slave (
    input  in_vld, fp, db, normal,
    output out_vld, s, e, e_z, e_inf, h, fz, f, lz, nan, snan
  );
`else
  modport master (
    output in_vld, fp, db, normal,
    input  out_vld, s, e, e_z, e_inf, h, fz, f, lz
  );
  modport slave (
    input  in_vld, fp, db, normal,
    output out_vld, s, e, e_z, e_inf, h, fz, f, lz
  );
`endif

endinterface

// File: rtl/fp_unpacker_lzc53.sv
// -----------------------------------------------------------------------------
// lzc53
// Combinational leading-zero counter over a 53-bit significand.
//   sig[52:0] in  : value to scan, MSB first
//   lz[5:0]   out : number of zeros above the first 1; 53 when sig is zero
// -----------------------------------------------------------------------------
module lzc53
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  output logic [LZ_W-1:0]  lz
);

  // Scanning upward means the last hit is the most significant set bit,
  // so its position wins without needing a priority chain written out.
  always_comb begin
    // NOTE: lz gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    lz = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (sig[i]) lz = LZ_W'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_unpacker.sv
// -----------------------------------------------------------------------------
// fp_unpacker
// Registered IEEE-754 operand unpacker at the FPU input stage. Splits a packed
// double, or a single held in fp[63:32], into sign, raw exponent, fraction,
// significand and class flags, optionally left-normalising the significand.
// One-cycle latency, no back-pressure; a result is captured every cycle.
//   clk  in : clock, rising edge
//   rst  in : asynchronous, active-high reset; clears every output
//   bus     : fp_unpacker_if.slave (see interface header for the signal list)
// Optional feature macro: FP_UNPACK_NAN_EN adds registered nan/snan outputs.
// -----------------------------------------------------------------------------
module fp_unpacker
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_unpacker_if.slave bus
);

  logic [EXP_W-1:0]  exp_d;
  logic [FRAC_W-1:0] frac_d;
  logic              e_inf_d;
  logic              e_z_d;
  logic              fz_d;
  logic [SIG_W-1:0]  sig_d;
  logic [SIG_W-1:0]  f_d;
  logic [LZ_W-1:0]   lz_d;
  unpack_t           res_d;
  unpack_t           res_q;

  // Field select. A single's fraction is padded with zeros at the bottom, so
  // the counter and shifter below serve both formats without special cases.
  always_comb begin
    exp_d   = '0;
    frac_d  = '0;
    e_inf_d = 1'b0;
    if (bus.db) begin
      exp_d   = bus.fp[DBL_EXP_MSB:DBL_EXP_LSB];
      frac_d  = bus.fp[DBL_FRAC_MSB:DBL_FRAC_LSB];
      e_inf_d = (bus.fp[DBL_EXP_MSB:DBL_EXP_LSB] == DBL_EXP_ONES);
    end else begin
      exp_d   = {{(EXP_W - SGL_EXP_W){1'b0}}, bus.fp[SGL_EXP_MSB:SGL_EXP_LSB]};
      frac_d  = {bus.fp[SGL_FRAC_MSB:SGL_FRAC_LSB], {SGL_PAD{1'b0}}};
      e_inf_d = (bus.fp[SGL_EXP_MSB:SGL_EXP_LSB] == SGL_EXP_ONES);
    end
  end

  assign e_z_d = (exp_d == '0);
  assign fz_d  = (frac_d == '0);
  // Hidden bit is simply ~e_z; denormals keep e=0 and are not rebiased.
  assign sig_d = {~e_z_d, frac_d};

  lzc53 u_lzc (
    .sig (sig_d),
    .lz  (lz_d)
  );

  // A shift by 53 (zero operand) yields 0; normalised values have lz=0.
  assign f_d = bus.normal ? (sig_d << lz_d) : sig_d;

  always_comb begin
    res_d       = '0;
    res_d.vld   = bus.in_vld;
    res_d.s     = bus.fp[SIGN_BIT];
    res_d.e     = exp_d;
    res_d.e_z   = e_z_d;
    res_d.e_inf = e_inf_d;
    res_d.h     = frac_d;
    res_d.fz    = fz_d;
    res_d.f     = f_d;
    res_d.lz    = lz_d;
`ifdef FP_UNPACK_NAN_EN
    res_d.nan   = e_inf_d & ~fz_d;
    // Quiet bit is the fraction MSB in both formats thanks to left alignment.
    res_d.snan  = e_inf_d & ~fz_d & ~frac_d[FRAC_W-1];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign bus.out_vld = res_q.vld;
  assign bus.s       = res_q.s;
  assign bus.e       = res_q.e;
  assign bus.e_z     = res_q.e_z;
  assign bus.e_inf   = res_q.e_inf;
  assign bus.h       = res_q.h;
  assign bus.fz      = res_q.fz;
  assign bus.f       = res_q.f;
  assign bus.lz      = res_q.lz;
`ifdef FP_UNPACK_NAN_EN
  assign bus.nan     = res_q.nan;
  assign bus.snan    = res_q.snan;
`endif

endmodule

// File: tb/tb_fp_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fp_unpacker
// Scoreboard bench for fp_unpacker: the driver pushes a model-computed
// expectation for every valid operand, a negedge monitor pops and compares
// whenever out_vld is seen. Honours FP_UNPACK_NAN_EN for the nan/snan fields.
// -----------------------------------------------------------------------------
module tb_fp_unpacker;

  typedef struct {
    int           due;
    logic         s;
    logic [10:0]  e;
    logic         e_z;
    logic         e_inf;
    logic [51:0]  h;
    logic         fz;
    logic [52:0]  f;
    logic [5:0]   lz;
    logic         nan;
    logic         snan;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  fp_unpacker_if bus ();

  fp_unpacker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference model straight from the IEEE field definitions.
  function automatic exp_t model(input logic [63:0] x, input logic d, input logic n);
    exp_t        r;
    logic [52:0] sig;
    int          cnt;
    r.s = x[63];
    if (d) begin
      r.e     = x[62:52];
      r.h     = x[51:0];
      r.e_inf = (x[62:52] == 11'd2047);
    end else begin
      r.e     = {3'b000, x[62:55]};
      r.h     = {x[54:32], 29'd0};
      r.e_inf = (x[62:55] == 8'd255);
    end
    r.e_z  = (r.e == 11'd0);
    r.fz   = (r.h == 52'd0);
    sig    = {!r.e_z, r.h};
    cnt    = 0;
    while (cnt < 53 && sig[52-cnt] == 1'b0) cnt++;
    r.lz   = 6'(cnt);
    r.f    = n ? (sig << cnt) : sig;
    r.nan  = r.e_inf && !r.fz;
    r.snan = r.nan && !r.h[51];
    r.due  = 0;
    return r;
  endfunction

  task automatic apply(input logic v, input logic [63:0] x, input logic d, input logic n);
    exp_t r;
    bus.in_vld = v;
    bus.fp     = x;
    bus.db     = d;
    bus.normal = n;
    if (v) begin
      r     = model(x, d, n);
      r.due = cycle + 1;
      sb.push_back(r);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] x, input logic d, input logic n);
    @(posedge clk);
    #1;
    apply(v, x, d, n);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_vld"}, 64'(bus.out_vld), 64'd0);
    check({tag, "_s"},       64'(bus.s),       64'd0);
    check({tag, "_e"},       64'(bus.e),       64'd0);
    check({tag, "_e_z"},     64'(bus.e_z),     64'd0);
    check({tag, "_e_inf"},   64'(bus.e_inf),   64'd0);
    check({tag, "_h"},       64'(bus.h),       64'd0);
    check({tag, "_fz"},      64'(bus.fz),      64'd0);
    check({tag, "_f"},       64'(bus.f),       64'd0);
    check({tag, "_lz"},      64'(bus.lz),      64'd0);
`ifdef FP_UNPACK_NAN_EN
    check({tag, "_nan"},     64'(bus.nan),     64'd0);
    check({tag, "_snan"},    64'(bus.snan),    64'd0);
`endif
  endtask

  // Monitor: every out_vld must match the oldest outstanding expectation,
  // exactly one cycle after it was driven.
  always @(negedge clk) begin
    exp_t r;
    if (!rst && bus.out_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_out_vld", 64'(bus.out_vld), 64'd0);
      end else begin
        r = sb.pop_front();
        check("latency", 64'(cycle), 64'(r.due));
        check("s",     64'(bus.s),     64'(r.s));
        check("e",     64'(bus.e),     64'(r.e));
        check("e_z",   64'(bus.e_z),   64'(r.e_z));
        check("e_inf", 64'(bus.e_inf), 64'(r.e_inf));
        check("h",     64'(bus.h),     64'(r.h));
        check("fz",    64'(bus.fz),    64'(r.fz));
        check("f",     64'(bus.f),     64'(r.f));
        check("lz",    64'(bus.lz),    64'(r.lz));
`ifdef FP_UNPACK_NAN_EN
        check("nan",   64'(bus.nan),   64'(r.nan));
        check("snan",  64'(bus.snan),  64'(r.snan));
`endif
      end
    end
  end

  initial begin
    logic [63:0] x;
    logic [51:0] fr52;
    logic [22:0] fr23;
    logic        d;
    logic        n;
    logic        v;

    apply(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    check_cleared("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Directed operands, including the documented corner cases.
    drive(1'b1, 64'h0000000000000000, 1'b1, 1'b1);  // zero: lz=53 f=0
    drive(1'b1, 64'h3FF0000000000000, 1'b0, 1'b0);  // single 1.875-ish pattern
    drive(1'b1, 64'hBFF0000000000000, 1'b1, 1'b1);  // -1.0 double
    drive(1'b1, 64'h7FF0000000000000, 1'b0, 1'b0);  // single NaN (quiet)
    drive(1'b1, 64'h7FF0000000000000, 1'b1, 1'b0);  // double infinity
    drive(1'b1, 64'h0000000000000001, 1'b1, 1'b1);  // smallest denormal, normalised
    drive(1'b1, 64'h0000000000000001, 1'b1, 1'b0);  // smallest denormal, raw
    drive(1'b1, 64'h7F800001FFFFFFFF, 1'b0, 1'b1);  // single sNaN, low word ignored
    drive(1'b1, 64'h7FF0000000000001, 1'b1, 1'b0);  // double sNaN
    drive(1'b1, 64'h00000001AAAAAAAA, 1'b0, 1'b1);  // smallest single denormal
    drive(1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);  // idle cycle with garbage
    drive(1'b1, 64'h8000000000000000, 1'b0, 1'b1);  // single -0

    // Randomised operands biased toward zero/all-ones exponents and denormals.
    for (int i = 0; i < 400; i++) begin
      x = {$urandom(), $urandom()};
      d = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 4))
        0: if (d) x[62:52] = 11'd0; else x[62:55] = 8'd0;
        1: if (d) x[62:52] = 11'h7FF; else x[62:55] = 8'hFF;
        2: begin
          if (d) begin
            x[62:52] = 11'd0;
            fr52 = x[51:0] >> $urandom_range(0, 52);
            x[51:0] = fr52;
          end else begin
            x[62:55] = 8'd0;
            fr23 = x[54:32] >> $urandom_range(0, 23);
            x[54:32] = fr23;
          end
        end
        default: ;
      endcase
      drive(v, x, d, n);
    end

    // Reset between two valid operands: outputs clear at once, and the
    // operand presented at release appears one cycle later.
    drive(1'b1, 64'hC008000000000000, 1'b1, 1'b1);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_cleared("inrst");
    rst = 1'b0;
    apply(1'b1, 64'h4049000000000000, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
